// File: rtl/rvfi_trace_pkg.sv
// Shared RVFI retirement-record types, used by the trace FIFO and the debug-BFM glue.
package rvfi_trace_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned MASK_W     = 4;

  typedef struct packed {
    logic [XLEN-1:0]       insn;
    logic [XLEN-1:0]       pc;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]       rd_wdata;
    logic [XLEN-1:0]       mem_addr;
    logic [MASK_W-1:0]     mem_rmask;
    logic [MASK_W-1:0]     mem_wmask;
    logic [XLEN-1:0]       mem_rdata;
    logic [XLEN-1:0]       mem_wdata;
    logic                  trap;
  } rvfi_rec_t;

  // Record width tracks the field list above so storage can never disagree with the struct.
  localparam int unsigned RVFI_REC_W = $bits(rvfi_rec_t);

endpackage

// File: rtl/rvfi_fifo_core.sv
// Record storage with wrapping read/write pointers and an occupancy count.
// The caller guarantees push only when not full (or popping) and pop only when not empty.
module rvfi_fifo_core #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;

  // Payload slots carry no reset; validity is tracked entirely by r_level.
  always_ff @(posedge clock) begin
    if (push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so plain AW-bit increments wrap modulo DEPTH.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign rdata = r_mem[r_rd_ptr];
  assign level = r_level;

endmodule

// File: rtl/rvfi_trace_fifo.sv
// RVFI trace buffer: stores retired-instruction records, counts drops when full,
// marks the record after a drop with a gap flag, and freezes intake after a trap.
module rvfi_trace_fifo
  import rvfi_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   in_valid,
  input  rvfi_rec_t              in_rec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output rvfi_rec_t              out_rec,
  output logic                   out_gap,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       drop_count,
  output logic                   overflow,
  output logic                   halted,
  input  logic                   clear
);

  localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;
  localparam int unsigned SLOT_W = RVFI_REC_W + 1;

  logic [SLOT_W-1:0] w_wdata;
  logic [SLOT_W-1:0] w_rdata;
  logic [LVL_W-1:0]  w_level;
  logic              w_full;
  logic              w_pop;
  logic              w_push_req;
  logic              w_push;
  logic              w_drop;

  logic [CNT_W-1:0]  r_drop_count;
  logic              r_overflow;
  logic              r_halted;
  logic              r_gap_pending;

  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign w_full     = (w_level == LVL_W'(DEPTH));
  assign w_pop      = out_valid & out_ready;
  assign w_push_req = in_valid & ~r_halted;
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & ~w_push;

  // Each slot carries its own gap bit in the LSB.
  assign w_wdata = {in_rec, r_gap_pending};

  rvfi_fifo_core #(
    .WIDTH (SLOT_W),
    .DEPTH (DEPTH)
  ) u_core (
    .clock  (clock),
    .resetn (resetn),
    .push   (w_push),
    .wdata  (w_wdata),
    .pop    (w_pop),
    .rdata  (w_rdata),
    .level  (w_level)
  );

  // Drop accounting, gap tracking and halt; clear takes priority over any same-cycle event.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_drop_count  <= '0;
      r_overflow    <= 1'b0;
      r_halted      <= 1'b0;
      r_gap_pending <= 1'b0;
    end else if (clear) begin
      r_drop_count  <= '0;
      r_overflow    <= 1'b0;
      r_halted      <= 1'b0;
      r_gap_pending <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow    <= 1'b1;
        r_gap_pending <= 1'b1;
        if (r_drop_count != '1) begin
          r_drop_count <= r_drop_count + CNT_W'(1);
        end
      end else if (w_push) begin
        r_gap_pending <= 1'b0;
      end
      if (w_push && in_rec.trap) begin
        r_halted <= 1'b1;
      end
    end
  end

  // Slot payload is unreset, so the gap bit is qualified by occupancy.
  assign out_valid  = (w_level != '0);
  assign out_rec    = rvfi_rec_t'(w_rdata[SLOT_W-1:1]);
  assign out_gap    = w_rdata[0] & out_valid;
  assign level      = w_level;
  assign drop_count = r_drop_count;
  assign overflow   = r_overflow;
  assign halted     = r_halted;

endmodule
